// File: rtl/frame_snapshot_buffer.sv
// Double-buffered per-frame snapshot of the CPU video RAM.
// A vsync rise copies the source into the back bank, then the banks swap.
module frame_snapshot_buffer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 4,
  parameter int SRC_LATENCY = 1,
  parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR_LO = 'h10,
  parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR_HI = 'h89
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    vsync,
  output logic [ADDR_WIDTH-1:0]   src_addr,
  input  logic [DATA_WIDTH-1:0]   src_data,
  input  logic [ADDR_WIDTH-1:0]   frame_addr,
  output logic [DATA_WIDTH-1:0]   frame_data,
  output logic [2*DATA_WIDTH-1:0] sprite_enable_status,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    overrun,
  input  logic                    overrun_clear
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH-1);
  localparam logic [2:0] DRAIN_LAST = 3'(SRC_LATENCY-1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, SWAP} state_t;
  state_t state, state_d;

  logic                    vsync_q;
  logic                    vsync_rise;
  logic [2:0]              drain_cnt;
  logic                    front_sel;
  logic [SRC_LATENCY-1:0]  pipe_v;
  logic [ADDR_WIDTH-1:0]   pipe_a [SRC_LATENCY];
  logic                    tail_v;
  logic [ADDR_WIDTH-1:0]   tail_a;
  logic [2*DATA_WIDTH-1:0] status_stage;
  logic [DATA_WIDTH-1:0]   mem [2*DEPTH];

  assign vsync_rise = vsync & ~vsync_q;
  assign tail_v = pipe_v[SRC_LATENCY-1];
  assign tail_a = pipe_a[SRC_LATENCY-1];

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (vsync_rise) state_d = ISSUE;
      ISSUE:   if (src_addr == LAST) state_d = DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_LAST) state_d = SWAP;
      SWAP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      vsync_q <= 1'b0;
      src_addr <= '0;
      drain_cnt <= '0;
      front_sel <= 1'b0;
      busy <= 1'b0;
      frame_done <= 1'b0;
      overrun <= 1'b0;
      sprite_enable_status <= '0;
      status_stage <= '0;
      pipe_v <= '0;
      for (int i = 0; i < SRC_LATENCY; i++) pipe_a[i] <= '0;
    end else begin
      state <= state_d;
      vsync_q <= vsync;
      busy <= (state_d != IDLE);
      frame_done <= (state_d == SWAP);
      if (state == ISSUE && src_addr != LAST)
        src_addr <= src_addr + ADDR_WIDTH'(1);
      else
        src_addr <= '0;
      if (state == DRAIN)
        drain_cnt <= drain_cnt + 3'd1;
      else
        drain_cnt <= '0;
      // in-flight reads: the tail lines up with src_data
      pipe_v[0] <= (state == ISSUE);
      pipe_a[0] <= src_addr;
      for (int i = 1; i < SRC_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_a[i] <= pipe_a[i-1];
      end
      if (tail_v && tail_a == STATUS_ADDR_LO)
        status_stage[DATA_WIDTH-1:0] <= src_data;
      if (tail_v && tail_a == STATUS_ADDR_HI)
        status_stage[2*DATA_WIDTH-1:DATA_WIDTH] <= src_data;
      if (state == SWAP) begin
        front_sel <= ~front_sel;
        sprite_enable_status <= status_stage;
      end
      if (vsync_rise && state != IDLE)
        overrun <= 1'b1;
      else if (overrun_clear)
        overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (tail_v)
      mem[{~front_sel, tail_a}] <= src_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      frame_data <= '0;
    else
      frame_data <= mem[{front_sel, frame_addr}];
  end

endmodule
